// File: rtl/aes256_inv_round_ctrl.sv
// Iterative AES-256 decryption controller: one inverse round per clock,
// round keys fetched by index from an external expanded-key store,
// valid/ready handshakes on both the ciphertext and plaintext sides.
module aes256_inv_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  fsm_e         fsm;
  logic [127:0] state_q;
  logic [127:0] isr_isb;
  logic [127:0] round_next;
  logic [127:0] final_next;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    logic [7:0] m;
    p = '0;
    t = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ t;
      t = xtime(t);
      m = m >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    return gf_mul(x127, x127);
  endfunction

  // Inverse S-box: inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y[0] = x[2] ^ x[5] ^ x[7];
    y[1] = x[3] ^ x[6] ^ x[0];
    y[2] = x[4] ^ x[7] ^ x[1];
    y[3] = x[5] ^ x[0] ^ x[2];
    y[4] = x[6] ^ x[1] ^ x[3];
    y[5] = x[7] ^ x[2] ^ x[4];
    y[6] = x[0] ^ x[3] ^ x[5];
    y[7] = x[1] ^ x[4] ^ x[6];
    return gf_inv(y ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  // Row r rotates right by r columns: dest (r,c) takes source (r,c-r).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invmixcolumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Datapath: the shared InvShiftRows/InvSubBytes stage feeds both round forms.
  always_comb begin
    isr_isb    = inv_sub_bytes(inv_shift_rows(state_q));
    final_next = isr_isb ^ rk_data;
    round_next = invmixcolumns(final_next);
  end

  // Round-key index presented to the key store for the current state.
  always_comb begin
    rk_addr = 4'd14;
    case (fsm)
      IDLE:    rk_addr = 4'd14;
      ROUND:   rk_addr = round;
      FINAL:   rk_addr = 4'd0;
      default: rk_addr = 4'd14;
    endcase
  end

  assign in_ready = (fsm == IDLE) && key_ready;
  assign out_data = state_q;

  // Controller FSM with registered state, round counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      state_q   <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && key_ready) begin
            state_q <= in_data ^ rk_data;
            round   <= 4'd13;
            busy    <= 1'b1;
            fsm     <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_next;
          if (round == 4'd1) begin
            round <= 4'd0;
            fsm   <= FINAL;
          end else begin
            round <= round - 4'd1;
          end
        end
        FINAL: begin
          state_q   <= final_next;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes256_inv_round_ctrl.md
# aes256_inv_round_ctrl

Iterative AES-256 decryption core controller for the receiver path. Accepts one 128-bit ciphertext block over a valid/ready handshake and runs the standard inverse cipher with one round per clock: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns, reusing the team's existing inverse S-box, inverse shift-rows and `invmixcolumns` combinational blocks. It fetches round keys from the expanded-key store by index, and returns the 128-bit plaintext over a second valid/ready handshake.

## Interface
- No parameters. The round count is fixed at 14 for AES-256.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_ready`  in  1  high when the expanded key schedule (w[0..14]) is complete and stable.
- `in_valid`  in  1  a ciphertext block is offered.
- `in_ready`  out  1  the block can accept a ciphertext.
- `in_data`  in  128  ciphertext. Byte 0 is `[127:120]`; bytes are column-major, so column c is `[127-32c -: 32]`.
- `rk_addr`  out  4  round-key index, range 0..14.
- `rk_data`  in  128  round key w[rk_addr]. This is a combinational (same-cycle) read; byte order is the same as `in_data`.
- `out_valid`  out  1  plaintext is available.
- `out_ready`  in  1  the consumer accepts the plaintext.
- `out_data`  out  128  plaintext.
- `busy`  out  1  high in ROUND, FINAL and DONE.
- `round`  out  4  current round index, for debug and status.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - Outputs: `in_ready = key_ready`, `rk_addr = 14`.
  - On accept (`in_valid & in_ready`): `state <= in_data ^ rk_data`, `round <= 13`, go to ROUND.
- **ROUND**
  - Output `rk_addr = round`.
  - Update: `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data)`.
  - If `round == 1`: go to FINAL with `round <= 0`. Otherwise `round <= round - 1`.
- **FINAL**
  - Output `rk_addr = 0`.
  - Update: `state <= InvSubBytes(InvShiftRows(state)) ^ rk_data`. Go to DONE.
- **DONE**
  - Outputs: `out_valid = 1`, `out_data = state`.
  - On `out_ready`, go to IDLE.
  - Back-pressure: `out_data` and `out_valid` hold indefinitely while `out_ready` is low.
- InvShiftRows: row r rotates right by r columns. Row r of column c is byte `4c + r`.
- Every operation is bytewise GF(2^8) with the polynomial 0x11B. There is no width growth.
- `in_ready` is low in every state except IDLE. No new block is accepted until the previous result has been taken.
- The key store must keep w[0..14] stable while `busy` is high. `key_ready` is sampled only in IDLE, and a drop in `key_ready` mid-block is ignored.
- `state` is not cleared between blocks. `out_data` is valid only while `out_valid` is high.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - FSM = IDLE, `state` = 0, `round` = 0.
  - `out_valid` = 0, `busy` = 0, `out_data` = 0.
  - `in_ready` = `key_ready` (combinational from IDLE).
  - `rk_addr` = 14.
- Latency: accept at edge E, then 13 ROUND edges (E+1..E+13) and the FINAL edge (E+14). `out_valid` rises right after edge E+14.
- Key index by cycle: `rk_addr` is 14 in the accept cycle and 13..1 over the following 13 cycles. It is 0 in the FINAL cycle.
- Back-to-back throughput: if `out_ready` is held high, DONE lasts 1 cycle and `in_ready` returns the cycle after. This gives one block per 16 cycles.
- Reset mid-operation aborts the block with no output. The controller accepts again once `rst` falls and `key_ready` is high.
- There is no combinational path from `out_ready` to `out_valid`, or from `in_valid` to `in_ready`.

## Test plan
- **FIPS-197 C.3 vector.** Bench model holds the key schedule for key 000102…1f with `key_ready = 1`. Drive `in_data = 8ea2b7ca516745bfeafc49904b496089`.
  - Plaintext 00112233445566778899aabbccddeeff with `out_valid` high exactly 14 cycles after accept.
  - `rk_addr` sequence 14, 13, …, 1, 0.
- **Gated by key_ready.** `key_ready = 0` with `in_valid = 1` → `in_ready = 0` and no accept. Raise `key_ready` → accept on the next edge.
- **Output back-pressure.** Hold `out_ready = 0` for 10 cycles → `out_valid` and `out_data` stay stable and `in_ready` stays low. Pulse `out_ready` → back to IDLE next cycle.
- **Back-to-back blocks.** Two blocks with `out_ready` high, the second encrypted under the same key (bench reference model) → both plaintexts correct. The second accept comes 16 cycles after the first.
- **Reset mid-block.** Assert `rst` at ROUND with `round = 7` → `busy = 0`, `out_valid = 0` and `rk_addr = 14` immediately. No `out_valid` appears. A fresh C.3 block afterwards decrypts correctly.
- **Randomized.** 1000 random ciphertexts and keys, checked against the reference model, with random `out_ready` stalls → every output matches.
